dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
- REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  - clk  input  1  single clock; all state changes on rising edge.
  - reset  input  1  asynchronous, active-high reset.
  - req  input  1  access request; accepted on a rising edge where req && ready.
  - we  input  1  1 = store, 0 = load; sampled at acceptance.
  - size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is illegal.
  - unsigned_ld  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
  - addr  input  10  byte address, taken from the ALU ram_address output.
  - wdata  input  32  store data; sub-word data sits in the low bits.
  - ready  output  1  high only in IDLE.
  - done  output  1  one-cycle completion pulse.
  - rdata  output  32  load result; valid while done=1.
  - misalign_err  output  1  valid with done; marks a rejected access.

Function
- REQ-002 Storage SHALL be 256 x 32-bit words, indexed by addr[9:2], with little-endian byte lanes selected by addr[1:0].
- REQ-003 The FSM SHALL have the states IDLE, LOAD, MERGE and RESP; acceptance SHALL capture we, size, unsigned_ld, addr and wdata into registers.
- REQ-004 An access SHALL be flagged misaligned when size=01 with addr[0]=1, size=10 with addr[1:0]!=00, or size=11.
- REQ-005 A misaligned access SHALL perform no memory access; IDLE goes to RESP; done=1, misalign_err=1 and rdata=0, one cycle after acceptance.
- REQ-006 A word store SHALL write the array at the acceptance edge; IDLE goes to RESP; done=1 one cycle after acceptance.
- REQ-007 A load SHALL follow IDLE, then LOAD (synchronous array read), then RESP; done=1 two cycles after acceptance.
- REQ-007a For a load, rdata SHALL be the selected lane extended to 32 bits, sign- or zero-extended per unsigned_ld.
- REQ-008 A sub-word store SHALL follow IDLE, then LOAD (read the word), then MERGE (write the word with only the addressed lane(s) replaced), then RESP; done=1 three cycles after acceptance.
- REQ-009 In RESP, done SHALL be high for exactly one cycle and the state SHALL return to IDLE on the next edge; rdata and misalign_err SHALL be 0 outside RESP.
- REQ-010 ready SHALL be low from the acceptance edge until the FSM re-enters IDLE; req while ready=0 SHALL be ignored and SHALL not be queued.
- REQ-011 A load that follows a store to the same word SHALL return the stored data, because each access completes fully before the next is accepted.

Reset
- REQ-012 Asserting reset SHALL immediately force IDLE, ready=1, done=0, rdata=0 and misalign_err=0.
- REQ-013 Reset during LOAD SHALL abort a pending sub-word store with no array write; a word store already written at acceptance SHALL remain.
- REQ-014 Array contents SHALL NOT be cleared by reset.

Configuration
- REQ-015 Macro DMEM_SUBWORD_EN SHALL control sub-word support.
  - Defined: byte and halfword loads and stores work as in REQ-007/REQ-008.
  - Undefined: the MERGE state and lane-extension logic are absent, and any size!=10 SHALL be treated as misaligned under REQ-005.

Structure
- REQ-016 A shared package cpu_pkg SHALL hold DMEM_AW=10, DMEM_DEPTH=256, the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the dmem_state_t enum.
- REQ-017 The storage SHALL be a sub-module dmem_array: single-port, 256x32, synchronous read and write, with no reset.

Verification
- REQ-018 Word store addr=0x010, wdata=0xDEADBEEF, then word load addr=0x010: the store gives done 1 cycle after acceptance; the load gives done 2 cycles after acceptance with rdata=0xDEADBEEF.
- REQ-019 After REQ-018, byte store addr=0x011, wdata=0x55 (3-cycle done), then word load addr=0x010: rdata=0xDEAD55EF.
- REQ-020 Byte load addr=0x013 returns rdata=0xFFFFFFDE with unsigned_ld=0 and rdata=0x000000DE with unsigned_ld=1.
- REQ-021 Word load addr=0x012 gives done=1, misalign_err=1 and rdata=0 one cycle after acceptance, with the array unchanged; size=11 gives the same response.
- REQ-022 Halfword store addr=0x020 with reset asserted during LOAD: ready=1 and done=0 immediately, the word at 0x020 is unchanged, and req held high throughout is accepted on the first edge after reset deasserts.
- REQ-023 A build without DMEM_SUBWORD_EN: a byte load at addr=0x010 gives misalign_err=1, and word accesses behave as in REQ-018.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared data-memory types and helpers for the CPU slice.
// Sub-word lane helpers exist only when DMEM_SUBWORD_EN is defined.
package cpu_pkg;

    localparam int DMEM_AW    = 10;
    localparam int DMEM_DEPTH = 256;
    localparam int DMEM_IW    = $clog2(DMEM_DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MERGE,
        RESP
    } dmem_state_t;

    // Without sub-word support only aligned words are legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
`ifdef DMEM_SUBWORD_EN
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
`else
        return (size != SZ_WORD) || (off != 2'b00);
`endif
    endfunction

`ifdef DMEM_SUBWORD_EN
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: return {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] new_data,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {24'h0, new_data[7:0]} << {off, 3'b000};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {off[1], 4'b0000};
                data = {16'h0, new_data[15:0]} << {off[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = new_data;
            end
        endcase
        return (old_word & ~mask) | (data & mask);
    endfunction
`endif

endpackage

// File: rtl/dmem_array.sv
// Single-port 256x32 data RAM; synchronous read and write, contents survive reset.
module dmem_array
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [DMEM_IW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [DMEM_DEPTH];

    // Read returns the pre-write contents when a write hits the same word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: aligned-access checking, load extension and sub-word store merge.
// Define DMEM_SUBWORD_EN to enable byte/halfword accesses; otherwise only words are legal.
module dmem_ctrl
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               we,
    input  logic [1:0]         size,
    input  logic               unsigned_ld,
    input  logic [DMEM_AW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic               ready,
    output logic               done,
    output logic [31:0]        rdata,
    output logic               misalign_err
);

    dmem_state_t        state;
    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [DMEM_AW-1:0] addr_q;
    logic [31:0]        wdata_q;

    logic               accept;
    logic               acc_mis;
    logic               acc_word_store;

    logic               arr_en;
    logic               arr_we;
    logic [DMEM_IW-1:0] arr_addr;
    logic [31:0]        arr_wdata;
    logic [31:0]        arr_rdata;

`ifdef DMEM_SUBWORD_EN
    logic [31:0]        merge_q;
`else
    logic               unused_capture;
    assign unused_capture = ^{we_q, size_q, uns_q, addr_q, wdata_q};
`endif

    assign accept         = req && ready;
    assign acc_mis        = is_misaligned(size, addr[1:0]);
    assign acc_word_store = we && (size == SZ_WORD);

    // The array is read (or word-written) straight from the request at acceptance,
    // so the read word is already available throughout LOAD.
    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = addr[DMEM_AW-1:2];
        arr_wdata = wdata;
        if (accept && !acc_mis) begin
            arr_en = 1'b1;
            arr_we = acc_word_store;
        end
`ifdef DMEM_SUBWORD_EN
        if (state == MERGE) begin
            arr_en    = 1'b1;
            arr_we    = 1'b1;
            arr_addr  = addr_q[DMEM_AW-1:2];
            arr_wdata = merge_q;
        end
`endif
    end

    dmem_array u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            done         <= 1'b0;
            rdata        <= '0;
            misalign_err <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef DMEM_SUBWORD_EN
            merge_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= unsigned_ld;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        ready   <= 1'b0;
                        if (acc_mis) begin
                            state        <= RESP;
                            done         <= 1'b1;
                            misalign_err <= 1'b1;
                        end else if (acc_word_store) begin
                            state <= RESP;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
`ifdef DMEM_SUBWORD_EN
                    if (we_q) begin
                        merge_q <= lane_merge(arr_rdata, wdata_q, addr_q[1:0], size_q);
                        state   <= MERGE;
                    end else begin
                        rdata <= lane_extract(arr_rdata, addr_q[1:0], size_q, uns_q);
                        done  <= 1'b1;
                        state <= RESP;
                    end
`else
                    rdata <= arr_rdata;
                    done  <= 1'b1;
                    state <= RESP;
`endif
                end
`ifdef DMEM_SUBWORD_EN
                MERGE: begin
                    done  <= 1'b1;
                    state <= RESP;
                end
`endif
                RESP: begin
                    done         <= 1'b0;
                    rdata        <= '0;
                    misalign_err <= 1'b0;
                    ready        <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    done         <= 1'b0;
                    rdata        <= '0;
                    misalign_err <= 1'b0;
                    ready        <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl against a byte-addressed reference model.
// Honours DMEM_SUBWORD_EN the same way as the design.
module tb_dmem_ctrl;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        misalign_err;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          acc_cycle;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem_b [1024];
    int         cycle = 0;
    int         checks = 0;
    int         failures = 0;

    dmem_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .size         (size),
        .unsigned_ld  (unsigned_ld),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .rdata        (rdata),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference behaviour computed from the access rules on a flat byte memory.
    function automatic exp_t model_access(input logic w, input logic [1:0] s, input logic u,
                                          input logic [9:0] a, input logic [31:0] d);
        exp_t        e;
        int          nbytes;
        logic        mis;
        logic [31:0] val;
`ifdef DMEM_SUBWORD_EN
        mis = (s == 2'b11) || (s == SZ_HALF && a[0]) || (s == SZ_WORD && a[1:0] != 2'b00);
`else
        mis = (s != SZ_WORD) || (a[1:0] != 2'b00);
`endif
        nbytes = 1 << s;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.acc_cycle = 0;
        if (mis) begin
            e.lat = 1;
            e.err = 1'b1;
        end else if (w) begin
            for (int i = 0; i < nbytes; i++) mem_b[int'(a) + i] = d[8*i +: 8];
            e.lat = (s == SZ_WORD) ? 1 : 3;
        end else begin
            val = 32'h0;
            for (int i = 0; i < nbytes; i++) val = val | (32'(mem_b[int'(a) + i]) << (8 * i));
            if (!u && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
            e.rdata = val;
            e.lat   = 2;
        end
        return e;
    endfunction

    task automatic waitReady();
        for (int i = 0; i < 20 && ready !== 1'b1; i++) @(negedge clk);
        if (ready !== 1'b1) checkOutput("ready_wait_timeout", {31'h0, ready}, 32'h1);
    endtask

    task automatic pushExpect(input logic w, input logic [1:0] s, input logic u,
                              input logic [9:0] a, input logic [31:0] d);
        exp_t e;
        e = model_access(w, s, u, a, d);
        e.acc_cycle = cycle + 1;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] s, input logic u,
                                 input logic [9:0] a, input logic [31:0] d, input logic busy_pulse);
        waitReady();
        pushExpect(w, s, u, a, d);
        req = 1'b1; we = w; size = s; unsigned_ld = u; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        checkOutput("ready_low_after_accept", {31'h0, ready}, 32'h0);
        if (busy_pulse) begin
            req = 1'b1; we = 1'b1; size = SZ_WORD;
            addr = 10'(4 * $urandom_range(0, 15)); wdata = $urandom;
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    // Reset while the access sits in LOAD; optionally keep req high so it retries.
    task automatic resetDuringLoad(input logic hold_req);
        logic        w;
        logic [1:0]  s;
        logic [31:0] d;
`ifdef DMEM_SUBWORD_EN
        w = 1'b1; s = SZ_HALF; d = $urandom;
`else
        w = 1'b0; s = SZ_WORD; d = 32'h0;
`endif
        waitReady();
        req = 1'b1; we = w; size = s; unsigned_ld = 1'b0; addr = 10'h020; wdata = d;
        @(negedge clk);
        if (!hold_req) req = 1'b0;
        checkOutput("ready_low_in_load", {31'h0, ready}, 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("reset_ready", {31'h0, ready}, 32'h1);
        checkOutput("reset_done", {31'h0, done}, 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_err", {31'h0, misalign_err}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        if (hold_req) begin
            pushExpect(w, s, 1'b0, 10'h020, d);
            @(negedge clk);
            req = 1'b0;
            checkOutput("retry_accepted", {31'h0, ready}, 32'h0);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and polices idle outputs.
    always @(negedge clk) begin
        if (!reset) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("rdata", rdata, e.rdata);
                    checkOutput("misalign_err", {31'h0, misalign_err}, {31'h0, e.err});
                    checkOutput("latency", 32'(cycle - e.acc_cycle + 1), 32'(e.lat));
                end
            end else begin
                checkOutput("idle_outputs_zero", {31'h0, misalign_err} | rdata, 32'h0);
                if (sb.size() > 0 && (cycle - sb[0].acc_cycle + 1) > sb[0].lat + 3) begin
                    checkOutput("done_timeout", 32'(cycle - sb[0].acc_cycle + 1), 32'(sb[0].lat));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; size = SZ_WORD; unsigned_ld = 1'b0;
        addr = '0; wdata = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("por_ready", {31'h0, ready}, 32'h1);
        checkOutput("por_done", {31'h0, done}, 32'h0);
        checkOutput("por_rdata", rdata, 32'h0);
        checkOutput("por_err", {31'h0, misalign_err}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, SZ_WORD, 1'b0, 10'(4 * i), $urandom, 1'b0);

        applyStimulus(1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 1'b0);
        applyStimulus(1'b1, SZ_BYTE, 1'b0, 10'h011, 32'h55, 1'b0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 1'b0);
        applyStimulus(1'b0, SZ_BYTE, 1'b0, 10'h013, 32'h0, 1'b0);
        applyStimulus(1'b0, SZ_BYTE, 1'b1, 10'h013, 32'h0, 1'b0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 10'h012, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b11,   1'b0, 10'h010, 32'h0, 1'b0);
        applyStimulus(1'b1, SZ_WORD, 1'b0, 10'h012, 32'h12345678, 1'b1);
        applyStimulus(1'b1, 2'b11,   1'b0, 10'h010, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 1'b0);
        applyStimulus(1'b0, SZ_BYTE, 1'b0, 10'h010, 32'h0, 1'b0);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 10'h012, 32'h0, 1'b0);
        applyStimulus(1'b0, SZ_HALF, 1'b1, 10'h012, 32'h0, 1'b0);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 10'h011, 32'h0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          10'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 3) == 0));
        end

        resetDuringLoad(1'b0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 10'h020, 32'h0, 1'b0);
        resetDuringLoad(1'b1);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 10'h020, 32'h0, 1'b0);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) checkOutput("scoreboard_drain", 32'(sb.size()), 32'h0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
